ifetch_queue: RTL and testbench

//  - Fetch front end in front of the rv32i core pipeline.
//  - Issues word requests to instruction memory over a req/ack handshake with variable latency.
//  - Buffers returned instructions, with their PCs, in a DEPTH-entry FIFO.
//  - Presents the FIFO head to decode on a valid/ready handshake.
//  - Redirect input flushes the FIFO and restarts fetch at a new PC (branch/jump target).

---
 rtl/ifetch_queue.sv | 184 ++++++++++++++++++
 tb/tb_ifetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end for the rv32i pipeline.
// Issues one word request at a time to instruction memory, buffers the
// returned {pc, instruction} pairs in a DEPTH-entry FIFO and presents the
// head to decode on a valid/ready handshake. A redirect flushes the FIFO
// and restarts fetch; a redirect that lands on an unacknowledged request
// parks in DRAIN until that stale response returns.
// Optional feature: define IFQ_BYPASS_EN to forward an ack straight to
// decode when the FIFO is empty (zero-cycle fetch-to-decode latency).
module ifetch_queue #(
  parameter int unsigned      PC_W     = 8,
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   saved_pc_q, saved_pc_d;

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_nxt;

  logic ack_v;
  logic accept;
  logic flush;
  logic head_valid;
  logic push;
  logic pop;
  logic bypass_hit;
  logic bypass_take;

  // An ack only counts while our request is actually up
  assign ack_v      = imem_ack & req_q;
  assign head_valid = (count != '0);
  // Redirect kills any same-cycle pop
  assign pop        = head_valid & inst_ready & ~redirect;

`ifdef IFQ_BYPASS_EN
  // Forward the response directly when there is nothing queued ahead of it
  assign bypass_hit  = accept & ~head_valid;
  assign bypass_take = bypass_hit & inst_ready;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A forwarded-and-consumed response never occupies a slot
  assign push = accept & ~bypass_take;

  // Next FIFO occupancy
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Fetch FSM: next state, request and fetch PC
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    fetch_pc_d = fetch_pc_q;
    saved_pc_d = saved_pc_q;
    accept     = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      if (req_q && !ack_v) begin
        // Old request still in flight: keep it on the bus, remember target
        state_d    = DRAIN;
        saved_pc_d = redirect_pc;
        req_d      = 1'b1;
      end else begin
        state_d    = FETCH;
        fetch_pc_d = redirect_pc;
        req_d      = 1'b1;
      end
    end else if (state_q == DRAIN) begin
      if (ack_v) begin
        // Stale response is dropped; resume at the saved target
        state_d    = FETCH;
        fetch_pc_d = saved_pc_q;
        req_d      = 1'b0;
      end
    end else begin
      if (ack_v) begin
        accept     = 1'b1;
        fetch_pc_d = fetch_pc_q + PC_W'(4);
        req_d      = 1'b0;
      end else if (!req_q) begin
        // Raise only if the response is guaranteed a free slot
        req_d = (count_nxt < CW'(DEPTH));
      end
    end
  end

  // FSM and fetch address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      saved_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // FIFO storage; contents are qualified by count so need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fetch_pc_q;
      mem_data[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;

  // Decode-side outputs, zeroed when nothing is presented
  always_comb begin
    inst_valid = head_valid | bypass_hit;
    inst       = '0;
    inst_pc    = '0;
    if (head_valid) begin
      inst    = mem_data[rd_ptr];
      inst_pc = mem_pc[rd_ptr];
    end else if (bypass_hit) begin
      inst    = imem_rdata;
      inst_pc = fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue (default, non-bypass build).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  ifetch_queue #(
    .PC_W(8),
    .DATA_W(32),
    .DEPTH(4),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance falling edges until imem_req is seen, bounded
  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (imem_req !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) chk("req_timeout", {31'b0, imem_req}, 32'h1);
  endtask

  // One-cycle ack pulse; returns at the next falling edge
  task automatic do_ack(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req",   {31'b0, imem_req},   32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_pc;

    // ---- 1: reset state and steady fetch at 1 inst / 2 cycles
    @(negedge clk);
    @(negedge clk);
    chk("reset_req",   {31'b0, imem_req},   32'h0);
    chk("reset_addr",  {24'b0, imem_addr},  32'h00);
    chk("reset_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset_inst",  inst,                32'h0);
    chk("reset_pc",    {24'b0, inst_pc},    32'h0);
    inst_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      wait_req(10);
      chk("t1_addr", {24'b0, imem_addr}, 32'(i * 4));
      do_ack(32'h0000_0013);
      chk("t1_valid", {31'b0, inst_valid}, 32'h1);
      chk("t1_pc",    {24'b0, inst_pc},    32'(i * 4));
      chk("t1_inst",  inst,                32'h13);
      chk("t1_reqdrop", {31'b0, imem_req}, 32'h0);
    end
    @(negedge clk);
    chk("t1_empty", {31'b0, inst_valid}, 32'h0);
    chk("t1_next_addr", {24'b0, imem_addr}, 32'h0C);

    // ---- 2: fill to DEPTH with decode stalled
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_req(10);
      chk("t2_addr", {24'b0, imem_addr}, 32'(i * 4));
      do_ack(32'h100 + 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      chk("t2_full_noreq", {31'b0, imem_req}, 32'h0);
      chk("t2_head_pc", {24'b0, inst_pc}, 32'h00);
      @(negedge clk);
    end
    chk("t2_head_inst", inst, 32'h100);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume_req",  {31'b0, imem_req},  32'h1);
    chk("t2_resume_addr", {24'b0, imem_addr}, 32'h10);
    chk("t2_pop_pc",      {24'b0, inst_pc},   32'h04);
    chk("t2_pop_inst",    inst,               32'h101);

    // ---- 3: redirect with request outstanding -> drain
    do_reset();
    inst_ready = 1'b1;
    wait_req(10);
    do_ack(32'h11);
    wait_req(10);
    do_ack(32'h22);
    wait_req(10);
    chk("t3_addr8", {24'b0, imem_addr}, 32'h08);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    chk("t3_hold_req",  {31'b0, imem_req},   32'h1);
    chk("t3_hold_addr", {24'b0, imem_addr},  32'h08);
    chk("t3_flushed",   {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_hold_addr2", {24'b0, imem_addr}, 32'h08);
    do_ack(32'hDEAD_BEEF);
    chk("t3_discard", {31'b0, inst_valid}, 32'h0);
    wait_req(10);
    chk("t3_new_addr", {24'b0, imem_addr}, 32'h40);
    do_ack(32'h33);
    chk("t3_pc",   {24'b0, inst_pc}, 32'h40);
    chk("t3_inst", inst,             32'h33);

    // ---- 4: redirect coinciding with ack
    wait_req(10);
    chk("t4_addr44", {24'b0, imem_addr}, 32'h44);
    redirect = 1'b1; redirect_pc = 8'h20;
    do_ack(32'hBAD0);
    redirect = 1'b0;
    chk("t4_addr20", {24'b0, imem_addr}, 32'h20);
    chk("t4_req20",  {31'b0, imem_req},  32'h1);
    redirect = 1'b1; redirect_pc = 8'h80;
    do_ack(32'hBAD1);
    redirect = 1'b0;
    chk("t4_noentry", {31'b0, inst_valid}, 32'h0);
    chk("t4_addr80",  {24'b0, imem_addr},  32'h80);
    do_ack(32'h55);
    chk("t4_pc",   {24'b0, inst_pc}, 32'h80);
    chk("t4_inst", inst,             32'h55);

    // ---- 5: PC wrap
    wait_req(10);
    redirect = 1'b1; redirect_pc = 8'hF8;
    do_ack(32'hBAD2);
    redirect = 1'b0;
    exp_pc = 8'hF8;
    for (int i = 0; i < 3; i++) begin
      wait_req(10);
      chk("t5_addr", {24'b0, imem_addr}, {24'b0, exp_pc});
      do_ack(32'h1000 + 32'(i));
      chk("t5_pc",   {24'b0, inst_pc}, {24'b0, exp_pc});
      chk("t5_inst", inst,             32'h1000 + 32'(i));
      exp_pc = exp_pc + 8'd4;
    end

    // ---- 6: reset mid-transaction, late ack ignored
    do_reset();
    inst_ready = 1'b0;
    wait_req(10);
    do_ack(32'h61);
    wait_req(10);
    do_ack(32'h62);
    wait_req(10);
    chk("t6_pre_valid", {31'b0, inst_valid}, 32'h1);
    chk("t6_pre_addr",  {24'b0, imem_addr},  32'h08);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("t6_rst_req",   {31'b0, imem_req},   32'h0);
    chk("t6_rst_addr",  {24'b0, imem_addr},  32'h00);
    rst = 1'b0;
    do_ack(32'hBAD3);
    chk("t6_late_ack_valid", {31'b0, inst_valid}, 32'h0);
    chk("t6_restart_req",    {31'b0, imem_req},   32'h1);
    chk("t6_restart_addr",   {24'b0, imem_addr},  32'h00);
`ifdef IFQ_BYPASS_EN
    imem_ack   = 1'b1;
    imem_rdata = 32'h77;
    #1;
    chk("t6_bypass_valid", {31'b0, inst_valid}, 32'h1);
    chk("t6_bypass_pc",    {24'b0, inst_pc},    32'h00);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
`else
    do_ack(32'h77);
`endif
    chk("t6_valid", {31'b0, inst_valid}, 32'h1);
    chk("t6_pc",    {24'b0, inst_pc},    32'h00);
    chk("t6_inst",  inst,                32'h77);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
